// File: rtl/button_debouncer.sv
// Multi-channel push-button debouncer: 2-FF sync, stability counter, edge strobes.
// Optional long-press strobe when BUTTON_DEBOUNCER_HOLD_EN is defined.
module button_debouncer #(
   parameter int WIDTH    = 1,
   parameter int CNT_MAX  = 50000,
   parameter int CW       = 16,
   parameter int HOLD_MAX = 1000000,
   parameter int HW       = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] btn_raw,
   output logic [WIDTH-1:0] btn_db,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic [WIDTH-1:0] hold
);

   localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

   if (CNT_MAX < 1 || CNT_MAX > (1 << CW) - 1) begin : g_bad_cnt
      $error("button_debouncer: CNT_MAX out of range for CW");
   end
   if (HOLD_MAX < 1 || HOLD_MAX > (1 << HW) - 1) begin : g_bad_hold
      $error("button_debouncer: HOLD_MAX out of range for HW");
   end

   logic [WIDTH-1:0] s1;
   logic [WIDTH-1:0] s2;
   logic [CW-1:0]    cnt [WIDTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         s1     <= '0;
         s2     <= '0;
         btn_db <= '0;
         rise   <= '0;
         fall   <= '0;
         for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      end else begin
         s1   <= btn_raw;
         s2   <= s1;
         rise <= '0;
         fall <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            if (s2[i] == btn_db[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               btn_db[i] <= s2[i];
               cnt[i]    <= '0;
               rise[i]   <= s2[i];
               fall[i]   <= ~s2[i];
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

`ifdef BUTTON_DEBOUNCER_HOLD_EN
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);

   logic [HW-1:0]    hcnt [WIDTH];
   logic [WIDTH-1:0] fired;

   // One strobe per press: fired blocks re-arming until btn_db drops.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold  <= '0;
         fired <= '0;
         for (int i = 0; i < WIDTH; i++) hcnt[i] <= '0;
      end else begin
         hold <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            if (!btn_db[i]) begin
               hcnt[i]  <= '0;
               fired[i] <= 1'b0;
            end else if (!fired[i]) begin
               if (hcnt[i] == HOLD_LAST) begin
                  hold[i]  <= 1'b1;
                  fired[i] <= 1'b1;
               end else begin
                  hcnt[i] <= hcnt[i] + 1'b1;
               end
            end
         end
      end
   end
`else
   assign hold = '0;
`endif

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Multi-channel front end for raw mechanical push-buttons.
- Per channel: synchronises the asynchronous input, filters contact bounce with a stability counter, and produces a clean level.
- Also produces single-cycle rise/fall strobes.
- `btn_db` drives the `bi` input of the downstream one-pulse press FSM, one instance bit per button.

Parameters:
- WIDTH, 1, number of independent button channels.
- CNT_MAX, 50000, consecutive stable cycles required before the debounced level changes (legal range 1 to 2^CW-1).
- CW, 16, width of each per-channel stability counter.
- HOLD_MAX, 1000000, cycles `btn_db` must stay high before a hold strobe fires (used only with the optional feature).
- HW, 24, width of each per-channel hold counter.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- btn_raw  input  WIDTH  raw asynchronous button levels, 1 = pressed.
- btn_db  output  WIDTH  debounced, registered level per channel.
- rise  output  WIDTH  1-cycle strobe, asserted in the same cycle `btn_db` goes 0->1.
- fall  output  WIDTH  1-cycle strobe, asserted in the same cycle `btn_db` goes 1->0.
- hold  output  WIDTH  1-cycle long-press strobe; constant 0 when the feature is compiled out.

Behaviour:
- Reset (`rst` = 1 at a clock edge):
  - sync stage 1, sync stage 2, `btn_db`, `rise`, `fall`, `hold`, and all counters go to 0.
  - Reset takes priority over everything, including mid-count; any partial count is discarded.
- Synchroniser:
  - 2-FF chain per bit: s1 <= btn_raw, s2 <= s1.
  - Only s2 is used downstream.
- Stability counter, per channel i, evaluated every edge:
  - s2[i] == btn_db[i]: cnt[i] <= 0. Any bounce back to the current level restarts the count.
  - s2[i] != btn_db[i] and cnt[i] < CNT_MAX-1: cnt[i] <= cnt[i]+1.
  - s2[i] != btn_db[i] and cnt[i] == CNT_MAX-1: btn_db[i] <= s2[i] and cnt[i] <= 0. `rise[i]` (new level 1) or `fall[i]` (new level 0) is registered high for exactly this one cycle.
- Latency:
  - Let edge k be the first edge at which s1 captures a new, stable `btn_raw` value.
  - `btn_db` changes at edge k+1+CNT_MAX.
  - CNT_MAX = 1 gives a pure 2-cycle synchroniser plus one register.
- Outputs are all registered; `rise`/`fall` are never high simultaneously on one channel.
- Channels are fully independent: simultaneous events on several bits are handled in parallel.
- Counter saturation: the counter never exceeds CNT_MAX-1, so no wrap-around.
- A glitch shorter than CNT_MAX cycles (after synchronisation) produces no output change and no strobe.

Optional Feature:
- Macro: BUTTON_DEBOUNCER_HOLD_EN.
- Defined:
  - Per-channel hold counter hcnt[i] (HW bits) and a fired flag.
  - While btn_db[i] == 1 and the flag is clear, hcnt increments.
  - When hcnt reaches HOLD_MAX-1, `hold[i]` pulses for 1 cycle and the flag is set; no repeat until release.
  - btn_db[i] == 0 clears hcnt[i] and the flag.
  - Reset clears all of these.
- Not defined: no hold counters are synthesised; `hold` is tied to 0.

Test Plan (WIDTH = 2, CNT_MAX = 4, HOLD_MAX = 8):
- Reset: `rst` high 3 cycles with btn_raw = 2'b11 -> btn_db, rise, fall, hold all 0 throughout; the count starts only after `rst` falls.
- Clean press on bit 0: btn_raw[0] 0->1 sampled at edge k, held -> btn_db[0] = 1 and rise[0] = 1 at edge k+5, rise[0] = 0 at edge k+6; bit 1 is unaffected.
- Bounce: btn_raw[0] toggles 1,0,1,0 with 2-cycle periods, then stays 1 -> no rise until 5 edges after the final stable 1 is first sampled; exactly one rise pulse.
- Release with both channels: btn_db = 2'b11, btn_raw 11->00 in the same cycle -> fall = 2'b11 in one cycle, btn_db = 2'b00 at the same edge.
- Reset mid-count: press held 3 cycles after sampling, `rst` pulsed 1 cycle -> no rise; after `rst`, a full CNT_MAX+1 cycles of stability are needed again.
- Hold (macro defined): keep bit 1 pressed 20 cycles after btn_db[1] rises -> a single hold[1] pulse 8 cycles after btn_db[1] = 1, no further pulses; macro undefined -> hold = 0 throughout.
